// File: rtl/defaults_stream_gen.sv
// Purpose : latches four signed arguments and a count (each from its port or a
//           compile-time default), then streams n tuples (a+i*b, c+i*d) and pulses _done.
// Latency : first tuple valid 1 cycle after the accepting _start; 1 tuple/cycle with _ready high.
// Backpressure: with _valid=1 and _ready=0, outputs hold stable until accepted.
//
// Ports:
//   _clock, _reset_n           rising-edge clock, synchronous active-low reset
//   _start, _use_default[4:0]  start request (IDLE only); mask bits 0-3 = a,b,c,d, bit 4 = n
//   a, b, c, d, n              signed arguments / tuple count, sampled on the accepting _start
//   _ready / _valid            stream handshake
//   _out0, _out1               tuple outputs
//   _done                      one-cycle pulse after the final tuple is accepted
//   _last                      high on the final tuple (only with DEFAULTS_STREAM_GEN_LAST_EN)
// Optional feature macro: DEFAULTS_STREAM_GEN_LAST_EN
module defaults_stream_gen #(
  parameter int                      WIDTH     = 32,
  parameter logic signed [WIDTH-1:0] DEFAULT_A = WIDTH'(1),
  parameter logic signed [WIDTH-1:0] DEFAULT_B = WIDTH'(2),
  parameter logic signed [WIDTH-1:0] DEFAULT_C = WIDTH'(3),
  parameter logic signed [WIDTH-1:0] DEFAULT_D = WIDTH'(4),
  parameter logic signed [WIDTH-1:0] DEFAULT_N = WIDTH'(8)
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    _start,
  input  logic [4:0]              _use_default,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  input  logic signed [WIDTH-1:0] n,
  input  logic                    _ready,
  output logic                    _valid,
  output logic signed [WIDTH-1:0] _out0,
  output logic signed [WIDTH-1:0] _out1,
  output logic                    _done
`ifdef DEFAULTS_STREAM_GEN_LAST_EN
  ,
  output logic                    _last
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] b_q;
  logic signed [WIDTH-1:0] d_q;
  logic [WIDTH-1:0]        idx;
  logic [WIDTH-1:0]        last_idx;   // n-1, compared against idx each handshake

  logic signed [WIDTH-1:0] eff_a;
  logic signed [WIDTH-1:0] eff_b;
  logic signed [WIDTH-1:0] eff_c;
  logic signed [WIDTH-1:0] eff_d;
  logic signed [WIDTH-1:0] eff_n;
  logic                    eff_n_empty;

  always_comb begin
    eff_a       = _use_default[0] ? DEFAULT_A : a;
    eff_b       = _use_default[1] ? DEFAULT_B : b;
    eff_c       = _use_default[2] ? DEFAULT_C : c;
    eff_d       = _use_default[3] ? DEFAULT_D : d;
    eff_n       = _use_default[4] ? DEFAULT_N : n;
    // n <= 0 as a signed value: negative sign bit or exactly zero
    eff_n_empty = eff_n[WIDTH-1] || (eff_n == '0);
  end

  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      state    <= IDLE;
      _valid   <= 1'b0;
      _done    <= 1'b0;
      _out0    <= '0;
      _out1    <= '0;
      idx      <= '0;
      last_idx <= '0;
      b_q      <= '0;
      d_q      <= '0;
`ifdef DEFAULTS_STREAM_GEN_LAST_EN
      _last    <= 1'b0;
`endif
    end else begin
      _done <= 1'b0;
      case (state)
        IDLE: begin
          if (_start) begin
            b_q      <= eff_b;
            d_q      <= eff_d;
            last_idx <= eff_n - ONE;
            idx      <= '0;
            if (eff_n_empty) begin
              // Nothing to emit: go straight to the done pulse.
              state <= DONE;
              _done <= 1'b1;
            end else begin
              state  <= RUN;
              _valid <= 1'b1;
              _out0  <= eff_a;
              _out1  <= eff_c;
`ifdef DEFAULTS_STREAM_GEN_LAST_EN
              _last  <= (eff_n == ONE);
`endif
            end
          end
        end
        RUN: begin
          // _valid is always 1 here, so _ready alone marks a handshake.
          if (_ready) begin
            if (idx == last_idx) begin
              state  <= DONE;
              _valid <= 1'b0;
              _done  <= 1'b1;
`ifdef DEFAULTS_STREAM_GEN_LAST_EN
              _last  <= 1'b0;
`endif
            end else begin
              idx   <= idx + ONE;
              _out0 <= _out0 + b_q;
              _out1 <= _out1 + d_q;
`ifdef DEFAULTS_STREAM_GEN_LAST_EN
              _last <= ((idx + ONE) == last_idx);
`endif
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_defaults_stream_gen.sv
module tb_defaults_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  mask;
  logic [31:0] a, b, c, d, n;
  logic        rdy = 1'b0;
  logic        valid, done;
  logic [31:0] out0, out1;
  logic        last;

  logic        w8_start;
  logic        w8_valid, w8_done;
  logic [7:0]  w8_out0, w8_out1;
  logic        w8_last;

  always #5 clk = ~clk;

  defaults_stream_gen dut (
    ._clock(clk), ._reset_n(rst_n), ._start(start), ._use_default(mask),
    .a(a), .b(b), .c(c), .d(d), .n(n), ._ready(rdy),
    ._valid(valid), ._out0(out0), ._out1(out1), ._done(done)
`ifdef DEFAULTS_STREAM_GEN_LAST_EN
    , ._last(last)
`endif
  );

  defaults_stream_gen #(.WIDTH(8)) dut8 (
    ._clock(clk), ._reset_n(rst_n), ._start(w8_start), ._use_default(5'b00000),
    .a(8'd120), .b(8'd10), .c(8'd0), .d(8'd0), .n(8'd2), ._ready(1'b1),
    ._valid(w8_valid), ._out0(w8_out0), ._out1(w8_out1), ._done(w8_done)
`ifdef DEFAULTS_STREAM_GEN_LAST_EN
    , ._last(w8_last)
`endif
  );

`ifndef DEFAULTS_STREAM_GEN_LAST_EN
  assign last    = 1'b0;
  assign w8_last = 1'b0;
`endif

  typedef struct {
    logic [31:0] o0;
    logic [31:0] o1;
    logic        lst;
  } exp_t;

  exp_t q[$];
  int   done_pending = 0;
  int   vec = 0;
  int   errs = 0;
  bit   mon_en = 0;

  // ready driver: 0 = always high, 1 = random, 2 = fixed toggle pattern
  int   rmode = 0;
  int   pidx = 0;
  int   pat[6] = '{1, 0, 0, 1, 0, 1};

  always @(posedge clk) begin
    #1;
    if (rmode == 0)      rdy = 1'b1;
    else if (rmode == 1) rdy = 1'($urandom_range(0, 1));
    else begin
      rdy  = (pat[pidx % 6] != 0);
      pidx = pidx + 1;
    end
  end

  // Monitor: pops expected tuples on every handshake, checks done and stall stability.
  bit          prev_stall = 0;
  logic [31:0] p0, p1;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        vec++;
        if (valid !== 1'b1 || out0 !== p0 || out1 !== p1) begin
          errs++;
          $display("FAIL stall_hold valid=%0b out=(%0d,%0d) want held (%0d,%0d)",
                   valid, $signed(out0), $signed(out1), $signed(p0), $signed(p1));
        end
      end
      if (valid === 1'b1 && rdy === 1'b1) begin
        vec++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL extra_tuple got (%0d,%0d) want none", $signed(out0), $signed(out1));
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out0 !== e.o0 || out1 !== e.o1) begin
            errs++;
            $display("FAIL tuple got (%0d,%0d) want (%0d,%0d)",
                     $signed(out0), $signed(out1), $signed(e.o0), $signed(e.o1));
          end
`ifdef DEFAULTS_STREAM_GEN_LAST_EN
          if (last !== e.lst) begin
            errs++;
            $display("FAIL last got %0b want %0b", last, e.lst);
          end
`endif
        end
      end
      if (done === 1'b1) begin
        vec++;
        if (done_pending == 0 || q.size() != 0 || valid !== 1'b0) begin
          errs++;
          $display("FAIL done_pulse got done=1 valid=%0b want done only after %0d pending tuples",
                   valid, q.size());
        end else begin
          done_pending--;
        end
      end
      prev_stall = (valid === 1'b1 && rdy !== 1'b1);
      p0 = out0;
      p1 = out1;
    end
  end

  task automatic start_job(input logic [4:0] m, input logic [31:0] ia, ib, ic, id, in_);
    logic signed [31:0] ea, eb, ec, ed, en;
    exp_t e;
    @(posedge clk); #1;
    mask = m; a = ia; b = ib; c = ic; d = id; n = in_;
    start = 1'b1;
    ea = m[0] ? 32'sd1 : ia;
    eb = m[1] ? 32'sd2 : ib;
    ec = m[2] ? 32'sd3 : ic;
    ed = m[3] ? 32'sd4 : id;
    en = m[4] ? 32'sd8 : in_;
    for (int i = 0; i < en; i++) begin
      e.o0  = ea + i * eb;
      e.o1  = ec + i * ed;
      e.lst = (i == en - 1);
      q.push_back(e);
    end
    done_pending++;
    @(posedge clk); #1;
    start = 1'b0;
    // arguments are don't-care once latched
    a = $urandom; b = $urandom; c = $urandom; d = $urandom; n = $urandom;
    mask = 5'($urandom);
    @(negedge clk);
    vec++;
    if (en > 0) begin
      if (valid !== 1'b1) begin
        errs++;
        $display("FAIL first_valid_latency got valid=%0b want 1", valid);
      end
    end else if (done !== 1'b1 || valid !== 1'b0) begin
      errs++;
      $display("FAIL empty_done got done=%0b valid=%0b want done=1 valid=0", done, valid);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000; k++) begin
      if (q.size() == 0 && done_pending == 0) break;
      @(negedge clk); #1;
    end
    vec++;
    if (q.size() != 0 || done_pending != 0) begin
      errs++;
      $display("FAIL job_timeout got %0d tuples and %0d done pulses outstanding want 0",
               q.size(), done_pending);
      q.delete();
      done_pending = 0;
    end
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; w8_start = 1'b0; mask = '0;
    a = '0; b = '0; c = '0; d = '0; n = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_valid", 32'(valid), 32'd0);
    check1("rst_done",  32'(done),  32'd0);
    check1("rst_out0",  out0, 32'd0);
    check1("rst_out1",  out1, 32'd0);
    check1("rst_last",  32'(last), 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1;

    // all defaults, full throughput
    rmode = 0;
    start_job(5'b11111, $urandom, $urandom, $urandom, $urandom, $urandom);
    wait_idle();
    // mixed mask
    start_job(5'b00101, 32'd99, -32'sd1, 32'd99, 32'd10, 32'd3);
    wait_idle();
    // backpressure pattern
    rmode = 2; pidx = 0;
    start_job(5'b00101, 32'd99, -32'sd1, 32'd99, 32'd10, 32'd3);
    wait_idle();
    rmode = 0;
    // empty and negative counts
    start_job(5'b00000, 32'd5, 32'd6, 32'd7, 32'd8, 32'd0);
    wait_idle();
    start_job(5'b00000, 32'd5, 32'd6, 32'd7, 32'd8, -32'sd5);
    wait_idle();

    // randomized jobs
    repeat (30) begin
      int nn;
      rmode = $urandom_range(0, 1);
      nn = int'($urandom_range(0, 12)) - 2;
      start_job(5'($urandom), $urandom, $urandom, $urandom, $urandom, nn);
      wait_idle();
    end
    rmode = 0;

    // busy start ignored, then reset mid-run, then clean restart
    start_job(5'b01111, 32'd0, 32'd0, 32'd0, 32'd0, 32'd20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; mask = 5'b00000;
    a = 32'd500; b = 32'd7; c = 32'd600; d = 32'd9; n = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    mon_en = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("midrst_valid", 32'(valid), 32'd0);
    check1("midrst_done",  32'(done),  32'd0);
    check1("midrst_out0",  out0, 32'd0);
    check1("midrst_out1",  out1, 32'd0);
    q.delete();
    done_pending = 0;
    mon_en = 1;
    start_job(5'b11111, $urandom, $urandom, $urandom, $urandom, $urandom);
    wait_idle();

    // 8-bit wrap
    @(posedge clk); #1;
    w8_start = 1'b1;
    @(posedge clk); #1;
    w8_start = 1'b0;
    @(negedge clk);
    check1("w8_valid0", 32'(w8_valid), 32'd1);
    check1("w8_out0_i0", 32'(w8_out0), 32'd120);
    check1("w8_last_i0", 32'(w8_last), 32'd0);
    @(negedge clk);
    check1("w8_out0_i1", 32'(w8_out0), 32'h82);
`ifdef DEFAULTS_STREAM_GEN_LAST_EN
    check1("w8_last_i1", 32'(w8_last), 32'd1);
`endif
    @(negedge clk);
    check1("w8_done", 32'(w8_done), 32'd1);
    check1("w8_valid_end", 32'(w8_valid), 32'd0);
    check1("w8_out1", 32'(w8_out1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
